spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares the single Master_SPI engine (one CS, ADXL362 on Nexys A7) between two transaction requesters, e.g. the periodic accelerometer sequencer (port 0) and a debug register-access client (port 1).
- Grants the whole SPI byte stream to one owner for a complete CS transaction, using round-robin arbitration.
- A watchdog forces release if an owner stalls.
- Sits between the requesters and Master_SPI; the requesters never drive Master_SPI directly.

Parameters:
MAX_BYTES_PER_CS, 2, must match Master_SPI; sets CW = $clog2(MAX_BYTES_PER_CS+1), the width of the count buses.
TIMEOUT, 1000000, maximum cycles one grant may last (10 ms at 100 MHz); must be ≥ 2.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
req0, req1  in  1  request; held high for the whole transaction
tx_dv0, tx_dv1  in  1  per-requester byte-valid pulse
tx_byte0, tx_byte1  in  8  per-requester byte
tx_count0, tx_count1  in  CW  per-requester bytes-per-CS
gnt0, gnt1  out  1  registered grant, one-hot or zero
tx_ready0, tx_ready1  out  1  TX_Ready gated by grant
rx_dv0, rx_dv1  out  1  RX_DV gated by grant
rx_byte  out  8  RX_Byte pass-through
rx_count  out  CW  RX_Count pass-through
TX_DV  out  1  to Master_SPI
TX_Byte  out  8  to Master_SPI
TX_Count  out  CW  to Master_SPI
TX_Ready  in  1  from Master_SPI
RX_DV  in  1  from Master_SPI
RX_Byte  in  8  from Master_SPI
RX_Count  in  CW  from Master_SPI
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values (synchronous, rst high at posedge):
  - State = IDLE; gnt0 = gnt1 = 0.
  - Watchdog counter = 0; timeout_err = 0; block0 = block1 = 0.
  - last_served = 1, so req0 wins the first tie.
  - Reset mid-transaction aborts the grant immediately; the Master_SPI transfer in flight is not tracked.
- FSM states: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - A requester is eligible when reqN = 1, blockN = 0 and TX_Ready = 1.
  - If only one is eligible, go to OWNn.
  - If both are eligible, grant the one ≠ last_served.
  - gntN rises one cycle after the eligible reqN is sampled.
  - There is always at least one IDLE cycle between consecutive grants.
- OWNn:
  - On entry, last_served = n and the watchdog counter is cleared.
  - The counter increments every cycle while in OWNn.
  - If reqN = 0 and TX_Ready = 1, go to IDLE.
  - If reqN = 0 and TX_Ready = 0, go to DRAIN.
  - If the counter = TIMEOUT-1 and reqN is still 1: go to DRAIN, set timeout_err = 1, set blockN = 1.
- DRAIN: gnt0 = gnt1 = 0; wait for TX_Ready = 1, then go to IDLE.
- blockN clears on the first cycle reqN = 0. A timed-out requester must drop req for at least one cycle before it can be re-granted.
- Datapath, combinational from the registered grant:
  - TX_DV = (tx_dv0 & gnt0) | (tx_dv1 & gnt1).
  - TX_Byte and TX_Count come from the owner's inputs; both are 0 when there is no grant.
  - tx_readyN = TX_Ready & gntN; rx_dvN = RX_DV & gntN.
  - A non-owner's tx_dv is ignored; it is never queued.
- TX_Count is held stable for the whole grant, because the owner must keep tx_countN constant.
- timeout_err clears only on rst.
- busy = (state ≠ IDLE).
- If req and tx_dv arrive in the same cycle, the tx_dv is dropped: a requester may pulse tx_dv only once gntN = 1.
- A reqN that rises while the other port owns the bus waits. It is guaranteed the next grant (round-robin), provided blockN = 0.

Test Plan:
- After rst, req0 = 1, TX_Ready = 1 → gnt0 = 1 one cycle later. Then tx_dv0 with tx_byte0 = 8'h0B, tx_count0 = 8 → TX_DV = 1, TX_Byte = 8'h0B, TX_Count = 8 in the same cycle.
- req0 and req1 rise in the same cycle with last_served = 1 → gnt0 first. Owner 0 releases → one IDLE cycle → gnt1. A second simultaneous request then goes to port 0.
- While OWN1, pulse tx_dv0 with tx_byte0 = 8'hAA → TX_DV and TX_Byte follow port 1 only. RX_DV pulses → rx_dv1 = 1, rx_dv0 = 0.
- Owner 0 drops req0 while TX_Ready = 0 → DRAIN, gnt0 = 0, busy = 1. TX_Ready rises → IDLE; the next grant follows one cycle later.
- TIMEOUT = 16, req1 held with no progress → after 16 cycles gnt1 = 0, timeout_err = 1. With req1 still high, no re-grant occurs. Drop req1 for one cycle and reassert → granted again; timeout_err stays 1.
- rst asserted mid-OWN0 → next cycle gnt0 = 0, TX_DV = 0, TX_Count = 0, timeout_err = 0. Simultaneous req0 and req1 then grant port 0.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that hands the single Master_SPI byte stream to one of
// two requesters for a whole CS transaction, with a stall watchdog that
// forces release and blocks the stalled port until it drops its request.
module spi_bus_arbiter #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int TIMEOUT          = 1000000,
  localparam int CW              = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          tx_dv0,
  input  logic          tx_dv1,
  input  logic [7:0]    tx_byte0,
  input  logic [7:0]    tx_byte1,
  input  logic [CW-1:0] tx_count0,
  input  logic [CW-1:0] tx_count1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          tx_ready0,
  output logic          tx_ready1,
  output logic          rx_dv0,
  output logic          rx_dv1,
  output logic [7:0]    rx_byte,
  output logic [CW-1:0] rx_count,
  output logic          TX_DV,
  output logic [7:0]    TX_Byte,
  output logic [CW-1:0] TX_Count,
  input  logic          TX_Ready,
  input  logic          RX_DV,
  input  logic [7:0]    RX_Byte,
  input  logic [CW-1:0] RX_Count,
  output logic          busy,
  output logic          timeout_err
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  state_t          state;
  state_t          next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;
  logic            block0;
  logic            block1;
  logic            last_served;
  logic            elig0;
  logic            elig1;

  assign elig0 = req0 & ~block0 & TX_Ready;
  assign elig1 = req1 & ~block1 & TX_Ready;

  // Next-state decode: arbitration in IDLE, release/watchdog while owned.
  always_comb begin
    next_state = state;
    wd_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 && elig1) next_state = last_served ? OWN0 : OWN1;
        else if (elig0)     next_state = OWN0;
        else if (elig1)     next_state = OWN1;
      end
      OWN0: begin
        if (!req0) begin
          next_state = TX_Ready ? IDLE : DRAIN;
        end else if (wd_cnt == WD_LIMIT) begin
          next_state = DRAIN;
          wd_fire    = 1'b1;
        end
      end
      OWN1: begin
        if (!req1) begin
          next_state = TX_Ready ? IDLE : DRAIN;
        end else if (wd_cnt == WD_LIMIT) begin
          next_state = DRAIN;
          wd_fire    = 1'b1;
        end
      end
      DRAIN: begin
        if (TX_Ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, registered grants, watchdog, fairness pointer and block flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      block0      <= 1'b0;
      block1      <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state <= next_state;
      gnt0  <= (next_state == OWN0);
      gnt1  <= (next_state == OWN1);
      // Grants are only entered from IDLE, so clearing outside OWN gives a
      // zero count on the first owned cycle.
      if (state == OWN0 || state == OWN1) wd_cnt <= wd_cnt + 1'b1;
      else                                 wd_cnt <= '0;
      if (wd_fire) timeout_err <= 1'b1;
      if (state == IDLE && next_state == OWN0) last_served <= 1'b0;
      if (state == IDLE && next_state == OWN1) last_served <= 1'b1;
      if (wd_fire && state == OWN0) block0 <= 1'b1;
      else if (!req0)               block0 <= 1'b0;
      if (wd_fire && state == OWN1) block1 <= 1'b1;
      else if (!req1)               block1 <= 1'b0;
    end
  end

  // Datapath steering from the registered grant; non-owner traffic is dropped.
  assign TX_DV     = (tx_dv0 & gnt0) | (tx_dv1 & gnt1);
  assign TX_Byte   = gnt0 ? tx_byte0 : (gnt1 ? tx_byte1 : 8'h00);
  assign TX_Count  = gnt0 ? tx_count0 : (gnt1 ? tx_count1 : '0);
  assign tx_ready0 = TX_Ready & gnt0;
  assign tx_ready1 = TX_Ready & gnt1;
  assign rx_dv0    = RX_DV & gnt0;
  assign rx_dv1    = RX_DV & gnt1;
  assign rx_byte   = RX_Byte;
  assign rx_count  = RX_Count;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: grant timing, round-robin order,
// non-owner isolation, drain, watchdog blocking and mid-transaction reset.
module tb_spi_bus_arbiter;

  localparam int MAXB = 8;
  localparam int TMO  = 16;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, tx_dv0, tx_dv1;
  logic [7:0]    tx_byte0, tx_byte1;
  logic [CW-1:0] tx_count0, tx_count1;
  logic          gnt0, gnt1, tx_ready0, tx_ready1, rx_dv0, rx_dv1;
  logic [7:0]    rx_byte;
  logic [CW-1:0] rx_count;
  logic          TX_DV;
  logic [7:0]    TX_Byte;
  logic [CW-1:0] TX_Count;
  logic          TX_Ready, RX_DV;
  logic [7:0]    RX_Byte;
  logic [CW-1:0] RX_Count;
  logic          busy, timeout_err;

  int compared = 0;
  int mismatched = 0;

  spi_bus_arbiter #(.MAX_BYTES_PER_CS(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .tx_dv0(tx_dv0), .tx_dv1(tx_dv1),
    .tx_byte0(tx_byte0), .tx_byte1(tx_byte1),
    .tx_count0(tx_count0), .tx_count1(tx_count1),
    .gnt0(gnt0), .gnt1(gnt1),
    .tx_ready0(tx_ready0), .tx_ready1(tx_ready1),
    .rx_dv0(rx_dv0), .rx_dv1(rx_dv1),
    .rx_byte(rx_byte), .rx_count(rx_count),
    .TX_DV(TX_DV), .TX_Byte(TX_Byte), .TX_Count(TX_Count),
    .TX_Ready(TX_Ready), .RX_DV(RX_DV), .RX_Byte(RX_Byte), .RX_Count(RX_Count),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 0; req1 = 0; tx_dv0 = 0; tx_dv1 = 0;
    tx_byte0 = 0; tx_byte1 = 0; tx_count0 = 0; tx_count1 = 0;
    TX_Ready = 1; RX_DV = 0; RX_Byte = 0; RX_Count = 0;
    tick(2);
    rst = 1'b0;
    #1;
    compared++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL reset_gnt: got %b%b want 00", gnt1, gnt0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    compared++; if (TX_DV !== 1'b0 || TX_Count !== 4'd0) begin mismatched++; $display("FAIL reset_tx: got dv=%b cnt=%0d want 0/0", TX_DV, TX_Count); end
  endtask

  task automatic test_single_grant;
    req0 = 1;
    #1;
    compared++; if (gnt0 !== 1'b0) begin mismatched++; $display("FAIL grant_not_early: got %b want 0", gnt0); end
    tick();
    compared++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL grant0: got g1g0=%b%b busy=%b want 01/1", gnt1, gnt0, busy); end
    compared++; if (tx_ready0 !== 1'b1 || tx_ready1 !== 1'b0) begin mismatched++; $display("FAIL tx_ready_gate: got %b%b want 01", tx_ready1, tx_ready0); end
    tx_dv0 = 1; tx_byte0 = 8'h0B; tx_count0 = 4'd8;
    #1;
    compared++; if (TX_DV !== 1'b1 || TX_Byte !== 8'h0B || TX_Count !== 4'd8) begin mismatched++; $display("FAIL tx_pass: got dv=%b byte=%h cnt=%0d want 1/0b/8", TX_DV, TX_Byte, TX_Count); end
    tick();
    tx_dv0 = 0; req0 = 0;
    tick();
    compared++; if (gnt0 !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL release0: got gnt0=%b busy=%b want 0/0", gnt0, busy); end
  endtask

  task automatic test_round_robin_and_isolation;
    rst = 1; tick(); rst = 0;
    req0 = 1; req1 = 1;
    tick();
    compared++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL rr_first: got %b%b want 01", gnt1, gnt0); end
    req0 = 0;
    tick();
    compared++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rr_idle_gap: got %b%b busy=%b want 00/0", gnt1, gnt0, busy); end
    tick();
    compared++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin mismatched++; $display("FAIL rr_second: got %b%b want 10", gnt1, gnt0); end
    tx_dv0 = 1; tx_byte0 = 8'hAA; tx_dv1 = 0; tx_byte1 = 8'h55; tx_count1 = 4'd3;
    #1;
    compared++; if (TX_DV !== 1'b0 || TX_Byte !== 8'h55 || TX_Count !== 4'd3) begin mismatched++; $display("FAIL non_owner_ignored: got dv=%b byte=%h cnt=%0d want 0/55/3", TX_DV, TX_Byte, TX_Count); end
    tx_dv1 = 1;
    #1;
    compared++; if (TX_DV !== 1'b1) begin mismatched++; $display("FAIL owner1_dv: got %b want 1", TX_DV); end
    tx_dv0 = 0; tx_dv1 = 0; RX_DV = 1; RX_Byte = 8'hC3; RX_Count = 4'd2;
    #1;
    compared++; if (rx_dv1 !== 1'b1 || rx_dv0 !== 1'b0) begin mismatched++; $display("FAIL rx_gate: got %b%b want 10", rx_dv1, rx_dv0); end
    compared++; if (rx_byte !== 8'hC3 || rx_count !== 4'd2) begin mismatched++; $display("FAIL rx_pass: got %h/%0d want c3/2", rx_byte, rx_count); end
    RX_DV = 0;
    req1 = 0;
    tick();
    req0 = 1; req1 = 1;
    tick();
    compared++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL rr_third: got %b%b want 01", gnt1, gnt0); end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_drain;
    req0 = 1;
    tick();
    compared++; if (gnt0 !== 1'b1) begin mismatched++; $display("FAIL drain_pre_grant: got %b want 1", gnt0); end
    TX_Ready = 0; req0 = 0;
    tick();
    compared++; if (gnt0 !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL drain_enter: got gnt0=%b busy=%b want 0/1", gnt0, busy); end
    req1 = 1;
    tick();
    compared++; if (busy !== 1'b1 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL drain_hold: got busy=%b gnt1=%b want 1/0", busy, gnt1); end
    TX_Ready = 1;
    tick();
    compared++; if (busy !== 1'b0 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL drain_exit: got busy=%b gnt1=%b want 0/0", busy, gnt1); end
    tick();
    compared++; if (gnt1 !== 1'b1) begin mismatched++; $display("FAIL drain_next_grant: got %b want 1", gnt1); end
    req1 = 0;
    tick();
  endtask

  task automatic test_timeout;
    req1 = 1;
    tick();
    tick(TMO - 1);
    compared++; if (gnt1 !== 1'b1 || timeout_err !== 1'b0) begin mismatched++; $display("FAIL wd_last_cycle: got gnt1=%b terr=%b want 1/0", gnt1, timeout_err); end
    tick();
    compared++; if (gnt1 !== 1'b0 || timeout_err !== 1'b1) begin mismatched++; $display("FAIL wd_fire: got gnt1=%b terr=%b want 0/1", gnt1, timeout_err); end
    tick(4);
    compared++; if (gnt1 !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL wd_blocked: got gnt1=%b busy=%b want 0/0", gnt1, busy); end
    req1 = 0;
    tick();
    req1 = 1;
    tick();
    compared++; if (gnt1 !== 1'b1 || timeout_err !== 1'b1) begin mismatched++; $display("FAIL wd_regrant: got gnt1=%b terr=%b want 1/1", gnt1, timeout_err); end
    req1 = 0;
    tick();
  endtask

  task automatic test_reset_mid;
    req0 = 1;
    tick();
    tx_dv0 = 1; tx_count0 = 4'd5;
    #1;
    compared++; if (gnt0 !== 1'b1 || TX_Count !== 4'd5) begin mismatched++; $display("FAIL mid_pre: got gnt0=%b cnt=%0d want 1/5", gnt0, TX_Count); end
    rst = 1;
    tick();
    compared++; if (gnt0 !== 1'b0 || TX_DV !== 1'b0 || TX_Count !== 4'd0 || timeout_err !== 1'b0) begin mismatched++; $display("FAIL mid_reset: got gnt0=%b dv=%b cnt=%0d terr=%b want 0/0/0/0", gnt0, TX_DV, TX_Count, timeout_err); end
    rst = 0; tx_dv0 = 0; req1 = 1;
    tick();
    compared++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL mid_tie: got %b%b want 01", gnt1, gnt0); end
    req0 = 0; req1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin_and_isolation();
    test_drain();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
